sensor_monitor: RTL

// - Multi-channel sensor fault monitor. Each channel carries a 4-bit sensor word {W,X,Y,Z} = sensors[4i+3:4i].
// - Per-channel fault rule: raw_err = Z | (Y & (W | X)).
// - Each raw fault is debounced over DEB_CYCLES consecutive samples, then latched per channel (sticky or live).
// - Newly qualified faults are counted. Sits between the sensor input pins and the system error/interrupt logic.

---
 rtl/sensor_monitor.sv | 133 +++++++++++++
 1 files changed

// File: rtl/sensor_monitor.sv
// sensor_monitor
//   Multi-channel sensor fault monitor. Every channel carries a 4-bit sensor
//   word {W,X,Y,Z}. A channel has a raw fault when Z | (Y & (W | X)) is true.
//   A raw fault must be present for DEB_CYCLES consecutive samples before it
//   qualifies. A qualified fault is latched in error_vec. With STICKY=1 it
//   stays set until clear or rst. With STICKY=0 it follows the debounced
//   fault. Each qualification event increments a saturating counter.
//
// Ports
//   clk        in   1         system clock, rising edge
//   rst        in   1         synchronous reset, active-high, highest priority
//   sensors    in   4*NUM_CH  raw sensor words, channel i = [4i+3:4i]
//   clear      in   1         synchronous clear of latched faults and debounce
//   error_vec  out  NUM_CH    per-channel qualified fault flag (registered)
//   error      out  1         OR of error_vec
//   err_count  out  CNT_W     saturating count of qualification events
module sensor_monitor #(
   parameter int NUM_CH     = 4,
   parameter int DEB_CYCLES = 3,
   parameter bit STICKY     = 1'b1,
   parameter int CNT_W      = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [4*NUM_CH-1:0]   sensors,
   input  logic                  clear,
   output logic [NUM_CH-1:0]     error_vec,
   output logic                  error,
   output logic [CNT_W-1:0]      err_count
);

   localparam int CW    = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;
   localparam int SUM_W = $clog2(NUM_CH + 1);
   localparam int TOT_W = ((CNT_W > SUM_W) ? CNT_W : SUM_W) + 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_PEND  = 2'd1,
      S_FAULT = 2'd2
   } state_t;

   logic [4*NUM_CH-1:0] samp;
   logic [NUM_CH-1:0]   raw_err;
   logic [NUM_CH-1:0]   qual_eff;

   // Input sample stage. Every raw decode uses this registered copy.
   // NOTE: registers use non-blocking assignments, so all flops update together at the edge.
   always_ff @(posedge clk) begin
      if (rst) samp <= '0;
      else     samp <= sensors;
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      state_t        state_q, state_d;
      logic [CW-1:0] cnt_q, cnt_d;
      logic          qual;

      // Bit order within a channel is W,X,Y,Z, from MSB to LSB.
      assign raw_err[g] = samp[4*g] | (samp[4*g+1] & (samp[4*g+3] | samp[4*g+2]));

      // NOTE: every combinational output gets a default first, so no latch is inferred.
      always_comb begin
         state_d = state_q;
         cnt_d   = cnt_q;
         qual    = 1'b0;
         case (state_q)
            S_IDLE, S_PEND: begin
               if (!raw_err[g]) begin
                  state_d = S_IDLE;
                  cnt_d   = '0;
               end else if (cnt_q == CW'(DEB_CYCLES - 1)) begin
                  // The qualify event. The counter holds while the fault stays latched.
                  qual    = 1'b1;
                  state_d = S_FAULT;
               end else begin
                  cnt_d   = cnt_q + CW'(1);
                  state_d = S_PEND;
               end
            end
            S_FAULT: begin
               if (!STICKY && !raw_err[g]) begin
                  state_d = S_IDLE;
                  cnt_d   = '0;
               end
            end
            default: begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end
         endcase
         // When clear and a qualify event fall on the same edge, clear wins.
         if (clear) begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
         end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
         end
      end

      // A qualify event that clear suppresses is not counted.
      assign qual_eff[g]  = qual & ~clear;
      assign error_vec[g] = (state_q == S_FAULT);
   end

   assign error = |error_vec;

   // Add all events on this edge in a wider sum, then clamp the result to the counter maximum.
   logic [SUM_W-1:0] qual_sum;
   logic [TOT_W-1:0] total;

   always_comb begin
      qual_sum = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         qual_sum = qual_sum + SUM_W'(qual_eff[i]);
      end
      total = TOT_W'(err_count) + TOT_W'(qual_sum);
   end

   always_ff @(posedge clk) begin
      if (rst)                                    err_count <= '0;
      else if (total > TOT_W'({CNT_W{1'b1}}))     err_count <= {CNT_W{1'b1}};
      else                                        err_count <= total[CNT_W-1:0];
   end

endmodule
